pointer_writer: RTL and testbench
=================================

# pointer_writer

Producer side of the sparse-activation pointer buffer. It consumes a dense row-major stream of activation values and counts the nonzero values in each row. It writes the CSR-style cumulative row pointers (ptr[0]=0, ptr[r+1] = nonzeros in rows 0..r) into the pointer buffer through that buffer's single-word write port. The compute engine then reads the complete pointer vector from the buffer's wide read port once `done` pulses.

## Interface
Parameters:
- DWIDTH, 8, pointer word width; also the width of the nonzero counter.
- AWIDTH, 5, pointer buffer address width.
- MEM_SIZE, 17, number of pointer entries; rows processed NUM_ROWS = MEM_SIZE-1.
- ROW_LEN, 16, elements per row.
- VWIDTH, 8, activation value width.

Ports:
- clk  in  1  clock. One clock domain; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a frame. Sampled only in IDLE.
- in_valid  in  1  a stream element is present on in_data.
- in_data  in  VWIDTH  activation value. Nonzero means any bit is set.
- in_ready  out  1  block accepts the element. An element is accepted on a cycle where in_valid and in_ready are both 1.
- ptr_ce  out  1  pointer buffer write-port enable.
- ptr_we  out  1  pointer buffer write enable. Always equal to ptr_ce.
- ptr_addr  out  AWIDTH  pointer index being written.
- ptr_d  out  DWIDTH  pointer value being written.
- busy  out  1  high from INIT through LAST.
- done  out  1  one-cycle pulse; all MEM_SIZE pointers are committed.
- nnz_total  out  DWIDTH  running nonzero count, saturating. Holds its final value after done until the next start.
- overflow  out  1  sticky; set when the count would exceed 2^DWIDTH-1. Cleared by start or rst.

## Operation
- FSM states: IDLE, INIT, RUN, LAST, DONE.
- IDLE: in_ready=0, busy=0. start=1 moves to INIT and clears cnt, col, row and overflow.
- INIT (1 cycle):
  - Drives the write ptr_addr=0, ptr_d=0, ptr_ce=ptr_we=1.
  - in_ready=0.
  - Next state is RUN.
- RUN:
  - in_ready=1. In_valid gaps (bubbles) are allowed and stall col.
  - On each accept:
    - If in_data!=0, cnt increments. It saturates at 2^DWIDTH-1; an increment attempted at saturation sets overflow.
    - col increments.
  - On the accept with col==ROW_LEN-1:
    - col returns to 0.
    - A write is registered for the next cycle: ptr_addr=row+1, ptr_d = cnt including this element.
    - row increments.
    - If this was row NUM_ROWS-1, next state is LAST. Otherwise the block stays in RUN, and accepts on the following cycle are legal while the write is on the port.
- LAST (1 cycle): presents the final write (addr MEM_SIZE-1), in_ready=0.
- DONE (1 cycle): done=1, busy=0, no write. Next state is IDLE.
- Zero-nonzero row: its pointer equals the previous pointer.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- rst in any state:
  - State goes to IDLE and counters clear.
  - Any pending write is dropped.
  - Entries already written stay in the buffer. No further writes are issued.

## Timing
- Reset values: in_ready=0, ptr_ce=0, ptr_we=0, ptr_addr=0, ptr_d=0, busy=0, done=0, nnz_total=0, overflow=0.
- All outputs are registered except in_ready, which is decoded from state.
- start high at cycle S (IDLE):
  - S+1: INIT, pointer 0 write on the port.
  - S+2: RUN, first possible accept.
- Last element of row r accepted at cycle T: the write for pointer r+1 is on the port during T+1.
- Last element of the frame accepted at T:
  - T+1: LAST, final write.
  - T+2: done=1.
  - T+3: IDLE. start is accepted from T+3.
- Gap-free stream: minimum frame length is 2 + NUM_ROWS*ROW_LEN + 2 cycles from start to done. With defaults, start at S gives done at S+259.
- Exactly MEM_SIZE writes per frame, with strictly increasing addresses 0..MEM_SIZE-1.
- Outside those write cycles ptr_ce=0.
- nnz_total updates in the cycle after each accept.

## Test plan
- All-zero frame, gap-free, defaults:
  - 17 writes, each with d=0, at addr 0..16.
  - done at S+259; nnz_total=0; overflow=0.
- Diagonal frame (element r nonzero in row r):
  - ptr[k]=k for k=0..16.
  - Write for row r appears one cycle after that row's last accept.
  - nnz_total=16.
- Same diagonal frame with random in_valid bubbles (~50%): identical write addresses and values; done is delayed by exactly the number of bubble cycles.
- All-nonzero frame (256 values of 0x01):
  - ptr[k]=16k for k ≤ 15; ptr[16]=255 (saturated).
  - overflow=1 from the 256th accept; nnz_total=255.
  - A new start clears overflow.
- rst asserted mid-row 5:
  - Outputs return to reset values on the next cycle.
  - No further ptr_ce.
  - A subsequent start runs a full frame correctly from addr 0.
- start pulsed during RUN and during DONE: ignored. Exactly 17 writes and one done pulse per accepted start.

Source files
------------

// File: rtl/pointer_writer.sv
// Producer side of the sparse-activation pointer buffer: counts nonzeros per row
// of a dense activation stream and writes cumulative CSR row pointers.
module pointer_writer #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 5,
  parameter int unsigned MEM_SIZE = 17,
  parameter int unsigned ROW_LEN  = 16,
  parameter int unsigned VWIDTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [VWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              ptr_ce,
  output logic              ptr_we,
  output logic [AWIDTH-1:0] ptr_addr,
  output logic [DWIDTH-1:0] ptr_d,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] nnz_total,
  output logic              overflow
);

  localparam int unsigned NUM_ROWS = MEM_SIZE - 1;
  localparam int unsigned CWIDTH   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RUN, LAST, DONE} state_t;

  state_t              state_q, state_d;
  logic [CWIDTH-1:0]   col_q, col_d;
  logic [AWIDTH-1:0]   row_q, row_d;
  logic [DWIDTH-1:0]   cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                ptr_ce_q, ptr_ce_d;
  logic [AWIDTH-1:0]   ptr_addr_q, ptr_addr_d;
  logic [DWIDTH-1:0]   ptr_d_q, ptr_d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    ptr_ce_d   = 1'b0;
    ptr_addr_d = '0;
    ptr_d_d    = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = INIT;
          col_d    = '0;
          row_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          ptr_ce_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      INIT: state_d = RUN;
      RUN: begin
        if (in_valid) begin
          if (|in_data) begin
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + DWIDTH'(1);
          end
          if (col_q == CWIDTH'(ROW_LEN - 1)) begin
            // Row pointer carries the count including the element accepted now.
            col_d      = '0;
            ptr_ce_d   = 1'b1;
            ptr_addr_d = row_q + AWIDTH'(1);
            ptr_d_d    = cnt_d;
            row_d      = row_q + AWIDTH'(1);
            if (row_q == AWIDTH'(NUM_ROWS - 1)) state_d = LAST;
          end else begin
            col_d = col_q + CWIDTH'(1);
          end
        end
      end
      LAST: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ptr_ce_q   <= 1'b0;
      ptr_addr_q <= '0;
      ptr_d_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ptr_ce_q   <= ptr_ce_d;
      ptr_addr_q <= ptr_addr_d;
      ptr_d_q    <= ptr_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign ptr_ce    = ptr_ce_q;
  assign ptr_we    = ptr_ce_q;
  assign ptr_addr  = ptr_addr_q;
  assign ptr_d     = ptr_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nnz_total = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pointer_writer.sv
// Directed bench for pointer_writer: a stream model predicts every pointer write
// (address, value, cycle) and the done pulse into queues checked by a monitor.
module tb_pointer_writer;

  localparam int unsigned DWIDTH   = 8;
  localparam int unsigned AWIDTH   = 5;
  localparam int unsigned MEM_SIZE = 17;
  localparam int unsigned ROW_LEN  = 16;
  localparam int unsigned VWIDTH   = 8;
  localparam int NUM_ROWS = MEM_SIZE - 1;
  localparam int DONE_LAT = 1 + NUM_ROWS * ROW_LEN + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [VWIDTH-1:0] in_data;
  logic              in_ready;
  logic              ptr_ce;
  logic              ptr_we;
  logic [AWIDTH-1:0] ptr_addr;
  logic [DWIDTH-1:0] ptr_d;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] nnz_total;
  logic              overflow;

  pointer_writer #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE),
    .ROW_LEN(ROW_LEN), .VWIDTH(VWIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ptr_ce(ptr_ce), .ptr_we(ptr_we), .ptr_addr(ptr_addr),
    .ptr_d(ptr_d), .busy(busy), .done(done), .nnz_total(nnz_total),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int d;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  n_writes = 0;
  int  n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (ptr_ce === 1'b1) begin
      n_writes++;
      chk("we_eq_ce", 32'(ptr_we), 32'd1);
      vectors++;
      assert (wq.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write observed addr=%0d d=%0d expected no write", ptr_addr, ptr_d);
      end
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_addr", 32'(ptr_addr), w.addr);
        chk("wr_data", 32'(ptr_d), w.d);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (done === 1'b1) begin
      n_done++;
      vectors++;
      assert (dq.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_done observed cycle=%0d expected none", cyc);
      end
      if (dq.size() != 0) chk("done_cycle", cyc, dq.pop_front());
    end
  end

  function automatic logic [VWIDTH-1:0] element(input int mode, input int r, input int c);
    logic [VWIDTH-1:0] one;
    one = 1;
    case (mode)
      1:       return (c == r) ? (one << (r % VWIDTH)) : '0;
      2:       return one;
      default: return '0;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_ce"}, 32'(ptr_ce), 0);
    chk({tag, "_we"}, 32'(ptr_we), 0);
    chk({tag, "_addr"}, 32'(ptr_addr), 0);
    chk({tag, "_d"}, 32'(ptr_d), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_nnz"}, 32'(nnz_total), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  // Gap-free unless bub; poke pulses start during RUN and DONE; abort_row>=0 resets mid-row.
  task automatic run_frame(input int mode, input bit bub, input bit poke, input int abort_row);
    int  exp_cnt, r, c, p, t0, nb, w0, d0;
    bit  exp_ovf, aborted;
    logic [VWIDTH-1:0] v;
    wr_t w;
    w0 = n_writes;
    d0 = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    p  = t0;
    w.addr = 0; w.d = 0; w.cyc = p;
    wq.push_back(w);
    in_valid = 1'b1;
    in_data  = '1;
    chk("init_busy", 32'(busy), 1);
    chk("init_ready", 32'(in_ready), 0);
    chk("init_nnz", 32'(nnz_total), 0);
    chk("init_ovf", 32'(overflow), 0);
    @(posedge clk); #1;
    p++;
    exp_cnt = 0; exp_ovf = 0; r = 0; c = 0; nb = 0; aborted = 0;
    while (r < NUM_ROWS) begin
      chk("run_ready", 32'(in_ready), 1);
      chk("run_nnz", 32'(nnz_total), exp_cnt);
      chk("run_ovf", 32'(overflow), 32'(exp_ovf));
      if (abort_row == r && c == 7) begin
        rst = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_outputs("abort");
        repeat (6) @(posedge clk);
        #1;
        chk("abort_writes", n_writes - w0, abort_row + 1);
        chk("abort_pending", wq.size(), 0);
        chk("abort_busy", 32'(busy), 0);
        aborted = 1;
        break;
      end
      start = (poke && r == 3 && c == 2);
      if (bub && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = VWIDTH'($urandom);
        nb++;
      end else begin
        v = element(mode, r, c);
        in_valid = 1'b1;
        in_data  = v;
        if (v != 0) begin
          if (exp_cnt == (1 << DWIDTH) - 1) exp_ovf = 1;
          else exp_cnt++;
        end
        if (c == ROW_LEN - 1) begin
          w.addr = r + 1; w.d = exp_cnt; w.cyc = p + 1;
          wq.push_back(w);
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      @(posedge clk); #1;
      p++;
    end
    start = 1'b0;
    if (!aborted) begin
      in_valid = 1'b1;
      in_data  = '1;
      chk("last_busy", 32'(busy), 1);
      chk("last_ready", 32'(in_ready), 0);
      dq.push_back(p + 1);
      chk("done_latency", (p + 1) - (t0 - 1), DONE_LAT + nb);
      @(posedge clk); #1;
      p++;
      in_valid = 1'b0;
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      if (poke) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("idle_done", 32'(done), 0);
      chk("idle_ready", 32'(in_ready), 0);
      chk("final_nnz", 32'(nnz_total), exp_cnt);
      chk("final_ovf", 32'(overflow), 32'(exp_ovf));
      repeat (4) @(posedge clk);
      #1;
      chk("hold_nnz", 32'(nnz_total), exp_cnt);
      chk("hold_busy", 32'(busy), 0);
      chk("frame_writes", n_writes - w0, MEM_SIZE);
      chk("frame_dones", n_done - d0, 1);
      chk("wq_empty", wq.size(), 0);
      chk("dq_empty", dq.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(1, 1'b0, 1'b0, -1);
    run_frame(1, 1'b1, 1'b0, -1);
    run_frame(2, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, -1);
    run_frame(2, 1'b0, 1'b0, 5);
    run_frame(1, 1'b0, 1'b0, -1);
    run_frame(1, 1'b1, 1'b1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
